strobe_scheduler: RTL
=====================

Name: strobe_scheduler

Overview:
Derives periodic one-cycle enable strobes for several drone subsystems (sensor poll, motor update, telemetry, housekeeping) from one shared prescaler. It replaces a separate divided clock per subsystem: everything stays on clk and uses enables. Per-channel periods and enables are programmed through a valid/ready config port. When several channels expire together, a round-robin arbiter serialises their strobes, at most one per cycle.

Parameters:
NUM_CH, 4, number of strobe channels (2..8)
CH_W, 3, cfg_ch width; must hold NUM_CH-1 plus out-of-range codes
PRESCALE, 10, clk cycles per base tick (>= 2)
PERIOD_W, 8, width of per-channel period in base ticks

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
cfg_ch  in  CH_W  channel index
cfg_period  in  PERIOD_W  period in base ticks (0 = never expires)
cfg_en  in  1  channel enable
cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= NUM_CH
strobe  out  NUM_CH  one-hot or zero; one-cycle strobe per grant
overrun  out  NUM_CH  sticky: expiry lost because that channel was already pending
ovr_clr  in  1  clears all overrun bits

Behaviour:
- Reset (async, resetn=0): prescale count=0; all enables, periods, down-counters and pending bits=0; strobe=0; overrun=0; cfg_err=0; RR pointer=NUM_CH-1 (ch0 highest priority first). cfg_ready is 1 as soon as reset is released.
- Prescaler: count runs 0..PRESCALE-1 and wraps. base_tick=1 exactly in the cycle where count==PRESCALE-1.
- Channel counter, on base_tick, only if enabled and period!=0:
  - cnt==0: set pending, reload cnt=period-1.
  - otherwise: cnt-1.
  - Period 1 expires every base tick. Period P expires every P base ticks.
- cfg_ready = ~base_tick (combinational). A config write never coincides with a counter update.
- Accepted write with valid channel, taking effect next edge: period=cfg_period, enable=cfg_en, cnt=cfg_period-1 (or 0 if cfg_period==0), pending cleared, overrun untouched. The first expiry therefore comes on the cfg_period-th base tick after the write.
- Accepted write with cfg_ch>=NUM_CH: no state change; cfg_err=1 for the following cycle only.
- Arbiter, every cycle:
  - If any pending bit is set, grant the first pending channel searching upward from RR pointer+1 with wrap.
  - Registered: strobe[g]=1 on the next cycle; pending[g] cleared; RR pointer=g.
  - At most one strobe bit per cycle.
- Latency: expiry on base_tick in cycle T sets pending at T+1. An uncontended strobe is visible in cycle T+2.
- Same channel expires while it is being granted in the same cycle: pending stays set (set wins) and the strobe still issues. This is not an overrun.
- Expiry while pending is already set and not granted that cycle: the expiry is dropped and overrun[ch] is set.
- ovr_clr coinciding with a new overrun on the same channel: the set wins.
- Disabling a channel (cfg_en=0) clears its pending bit, so no late strobe follows the write. A strobe already registered still completes.
- Reset mid-operation clears everything asynchronously. No strobe is issued after release until channels are reprogrammed.

Test Plan:
1. PRESCALE=4, write ch0 period=3 en=1 at cycle 0 (accepted).
   -> strobe[0] pulses every 12 clk cycles, each pulse 1 cycle wide.
   -> First pulse 2 cycles after the 3rd base_tick following the write.
2. PRESCALE=4, ch0..ch3 all period=1.
   -> On each base tick, strobes ch0,ch1,ch2,ch3 in 4 consecutive cycles (2,3,4,5 after base_tick).
   -> overrun stays 0.
   -> After the next base_tick the order restarts at ch0 (pointer now 3).
3. PRESCALE=2, ch0..ch3 period=1.
   -> Pending backlog builds; overrun bits become 1 within 3 base ticks.
   -> Pulse ovr_clr during a quiet window -> overrun reads 0 next cycle.
4. Hold cfg_valid=1 with cfg_ch=1 through the base_tick cycle.
   -> cfg_ready=0 in that cycle.
   -> Write accepted the following cycle; channel reloads from the new period.
5. Write cfg_ch=5 (NUM_CH=4).
   -> cfg_err=1 for exactly one cycle.
   -> No channel period, enable or strobe changes.
6. With ch2 pending (strobe not yet issued), drop resetn for 1 cycle mid-prescale.
   -> strobe=0 immediately and overrun=0.
   -> No strobe at all after release; count restarts at 0.

Source files
------------

// File: rtl/strobe_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : strobe_scheduler
// Brief   : Prescaled periodic enable strobes, serialised by a round-robin arbiter
// Rev     : 1.0  initial release
// ============================================================================
module strobe_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int CH_W     = 3,
   parameter int PRESCALE = 10,
   parameter int PERIOD_W = 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_en,
   output logic                cfg_err,
   output logic [NUM_CH-1:0]   strobe,
   output logic [NUM_CH-1:0]   overrun,
   input  logic                ovr_clr
);

   localparam int c_ps_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int c_ptr_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [c_ps_w-1:0]  c_ps_last  = c_ps_w'(PRESCALE - 1);
   localparam logic [c_ptr_w-1:0] c_ptr_rst  = c_ptr_w'(NUM_CH - 1);
   localparam logic [CH_W:0]      c_num_ch   = (CH_W + 1)'(NUM_CH);
   localparam logic [c_ptr_w:0]   c_num_ch_p = (c_ptr_w + 1)'(NUM_CH);

   logic [c_ps_w-1:0]   r_ps_cnt;
   logic                w_tick;

   logic                w_cfg_acc;
   logic                w_cfg_bad;
   logic [PERIOD_W-1:0] w_cfg_load;
   logic [NUM_CH-1:0]   w_wr;

   logic [NUM_CH-1:0]   r_en;
   logic [NUM_CH-1:0]   r_pend;
   logic [NUM_CH-1:0]   r_ovr;
   logic [PERIOD_W-1:0] r_period [NUM_CH];
   logic [PERIOD_W-1:0] r_cnt    [NUM_CH];
   logic [NUM_CH-1:0]   w_exp;

   logic [NUM_CH-1:0]   w_req;
   logic [NUM_CH-1:0]   w_gnt;
   logic [c_ptr_w-1:0]  w_gnt_idx;
   logic                w_found;
   logic [c_ptr_w:0]    w_sum;
   logic [c_ptr_w-1:0]  w_idx;

   logic [NUM_CH-1:0]   r_strobe;
   logic [c_ptr_w-1:0]  r_ptr;
   logic                r_err;

   // ---------------------------------------------------------------- prescaler
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ps_cnt <= '0;
      end else if (w_tick) begin
         r_ps_cnt <= '0;
      end else begin
         r_ps_cnt <= r_ps_cnt + 1'b1;
      end
   end

   assign w_tick = (r_ps_cnt == c_ps_last);

   // Config is refused on base_tick so a write never races a counter update.
   assign cfg_ready  = ~w_tick;
   assign w_cfg_acc  = cfg_valid & ~w_tick;
   assign w_cfg_bad  = ({1'b0, cfg_ch} >= c_num_ch);
   assign w_cfg_load = (cfg_period == '0) ? '0 : cfg_period - 1'b1;

   always_comb begin
      w_wr  = '0;
      w_exp = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_wr[i]  = w_cfg_acc & ~w_cfg_bad & (cfg_ch == CH_W'(i));
         w_exp[i] = w_tick & r_en[i] & (r_period[i] != '0) & (r_cnt[i] == '0);
      end
   end

   // ---------------------------------------------------------------- channels
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_en   <= '0;
         r_pend <= '0;
         r_ovr  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_period[i] <= '0;
            r_cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr[i]) begin
               r_period[i] <= cfg_period;
               r_en[i]     <= cfg_en;
               r_cnt[i]    <= w_cfg_load;
               r_pend[i]   <= 1'b0;
            end else begin
               if (w_tick && r_en[i] && (r_period[i] != '0)) begin
                  r_cnt[i] <= (r_cnt[i] == '0) ? r_period[i] - 1'b1 : r_cnt[i] - 1'b1;
               end
               // A new expiry re-arms pending even while it is being granted.
               r_pend[i] <= (r_pend[i] & ~w_gnt[i]) | w_exp[i];
            end
            if (w_exp[i] && r_pend[i] && !w_gnt[i]) begin
               r_ovr[i] <= 1'b1;
            end else if (ovr_clr) begin
               r_ovr[i] <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- arbiter
   // A channel being reconfigured this cycle is withheld so no stale strobe follows the write.
   assign w_req = r_pend & ~w_wr;

   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = r_ptr;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_sum = {1'b0, r_ptr} + (c_ptr_w + 1)'(k);
         if (w_sum >= c_num_ch_p) begin
            w_sum = w_sum - c_num_ch_p;
         end
         w_idx = w_sum[c_ptr_w-1:0];
         if (!w_found && w_req[w_idx]) begin
            w_found        = 1'b1;
            w_gnt[w_idx]   = 1'b1;
            w_gnt_idx      = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_strobe <= '0;
         r_ptr    <= c_ptr_rst;
         r_err    <= 1'b0;
      end else begin
         r_strobe <= w_gnt;
         r_err    <= w_cfg_acc & w_cfg_bad;
         if (w_found) begin
            r_ptr <= w_gnt_idx;
         end
      end
   end

   assign strobe  = r_strobe;
   assign overrun = r_ovr;
   assign cfg_err = r_err;

endmodule
`default_nettype wire
